ram_dual_port_sync_be: RTL and testbench

// - Single-clock true dual-port synchronous RAM, next generation of the core memory primitive.
// - Adds per-byte write enables, a configurable read pipeline with valid strobes and defined same-address collision rules.
// - Adds a post-reset clear state machine. Sits between core load/store and fetch/DMA paths as shared data memory.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_read_pipe.sv | 42 ++++
 rtl/ram_dual_port_sync_be.sv | 160 ++++++++++++++++
 tb/tb_ram_dual_port_sync_be.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR,
    RAM_READY
  } ram_state_t;

  // Byte count for the default 16-bit word; the RAM derives its own from DATA_WIDTH.
  localparam int unsigned BYTES = 16 / 8;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Per-port read return pipeline: READ_LATENCY stages of data/valid/error with synchronous flush.
module ram_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err
);

  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] d;
  logic [READ_LATENCY-1:0]                 v;
  logic [READ_LATENCY-1:0]                 e;

  // Data stages only advance with a valid word so the output holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      d <= '0;
      v <= '0;
      e <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_err;
      if (in_valid) d[0] <= in_data;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign data_out   = d[READ_LATENCY-1];
  assign data_valid = v[READ_LATENCY-1];
  assign parity_err = e[READ_LATENCY-1];

endmodule

// File: rtl/ram_dual_port_sync_be.sv
// Single-clock true dual-port RAM with byte enables, read pipeline and post-reset clear.
// Optional per-byte even parity storage and checking when RAM_PARITY_EN is defined.
module ram_dual_port_sync_be
  import ram_pkg::*;
#(
  parameter int unsigned           ADDRESS_WIDTH  = 16,
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           MEMORY_DEPTH   = 64,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       ready,
  input  logic                       enable_a,
  input  logic                       enable_b,
  input  logic                       rw_a,
  input  logic                       rw_b,
  input  logic [DATA_WIDTH/8-1:0]    byte_en_a,
  input  logic [DATA_WIDTH/8-1:0]    byte_en_b,
  input  logic [ADDRESS_WIDTH-1:0]   address_a,
  input  logic [ADDRESS_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]      data_in_a,
  input  logic [DATA_WIDTH-1:0]      data_in_b,
  output logic [DATA_WIDTH-1:0]      data_out_a,
  output logic [DATA_WIDTH-1:0]      data_out_b,
  output logic                       data_valid_a,
  output logic                       data_valid_b,
  output logic                       parity_err_a,
  output logic                       parity_err_b
);

  localparam int unsigned            NBYTES  = DATA_WIDTH / 8;
  localparam int unsigned            IDX_W   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]       LAST    = IDX_W'(MEMORY_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  ram_state_t       state, next_state;
  logic [IDX_W-1:0] clear_addr, next_clear_addr;
  logic             clear_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RAM_CLEAR;
      clear_addr <= '0;
    end else begin
      state      <= next_state;
      clear_addr <= next_clear_addr;
    end
  end

  // Without clearing, RAM_CLEAR lasts one cycle so ready rises the cycle after reset.
  always_comb begin
    next_state      = state;
    next_clear_addr = clear_addr;
    clear_we        = 1'b0;
    case (state)
      RAM_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clear_we        = 1'b1;
          next_clear_addr = clear_addr + 1'b1;
          if (clear_addr == LAST) next_state = RAM_READY;
        end else begin
          next_state = RAM_READY;
        end
      end
      RAM_READY: next_state = RAM_READY;
      default:   next_state = RAM_CLEAR;
    endcase
  end

  assign ready = (state == RAM_READY);

  logic             in_range_a, in_range_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;

  assign in_range_a = {1'b0, address_a} < DEPTH_L;
  assign in_range_b = {1'b0, address_b} < DEPTH_L;
  assign idx_a      = address_a[IDX_W-1:0];
  assign idx_b      = address_b[IDX_W-1:0];
  assign acc_a      = ready & ~reset & enable_a;
  assign acc_b      = ready & ~reset & enable_b;
  assign wr_a       = acc_a & rw_a & in_range_a;
  assign wr_b       = acc_b & rw_b & in_range_b;
  assign rd_a       = acc_a & ~rw_a;
  assign rd_b       = acc_b & ~rw_b;

  // Port A's byte lanes are written after port B's, so A wins any overlapping byte.
  always_ff @(posedge clock) begin
    if (clear_we && !reset) begin
      mem[clear_addr] <= CLEAR_VALUE;
    end else begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_b && byte_en_b[b]) mem[idx_b][8*b +: 8] <= data_in_b[8*b +: 8];
        if (wr_a && byte_en_a[b]) mem[idx_a][8*b +: 8] <= data_in_a[8*b +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  err_a, err_b;

  assign rdata_a = in_range_a ? mem[idx_a] : '0;
  assign rdata_b = in_range_b ? mem[idx_b] : '0;

`ifdef RAM_PARITY_EN
  logic [NBYTES-1:0] par [MEMORY_DEPTH];

  always_ff @(posedge clock) begin
    if (clear_we && !reset) begin
      for (int unsigned b = 0; b < NBYTES; b++)
        par[clear_addr][b] <= byte_parity(CLEAR_VALUE[8*b +: 8]);
    end else begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_b && byte_en_b[b]) par[idx_b][b] <= byte_parity(data_in_b[8*b +: 8]);
        if (wr_a && byte_en_a[b]) par[idx_a][b] <= byte_parity(data_in_a[8*b +: 8]);
      end
    end
  end

  always_comb begin
    err_a = 1'b0;
    err_b = 1'b0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (in_range_a) err_a = err_a | (byte_parity(mem[idx_a][8*b +: 8]) ^ par[idx_a][b]);
      if (in_range_b) err_b = err_b | (byte_parity(mem[idx_b][8*b +: 8]) ^ par[idx_b][b]);
    end
  end
`else
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  ram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) pipe_a (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (rd_a),
    .in_data    (rdata_a),
    .in_err     (err_a),
    .data_out   (data_out_a),
    .data_valid (data_valid_a),
    .parity_err (parity_err_a)
  );

  ram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) pipe_b (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (rd_b),
    .in_data    (rdata_b),
    .in_err     (err_b),
    .data_out   (data_out_b),
    .data_valid (data_valid_b),
    .parity_err (parity_err_b)
  );

endmodule

// File: tb/tb_ram_dual_port_sync_be.sv
// Bench for ram_dual_port_sync_be: vector table plus reset/clear sequences, scoreboarded read returns.
module tb_ram_dual_port_sync_be;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 1;
  localparam logic [15:0] CV    = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset;
  logic          ready;
  logic          enable_a, enable_b, rw_a, rw_b;
  logic [1:0]    byte_en_a, byte_en_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_in_a, data_in_b, data_out_a, data_out_b;
  logic          data_valid_a, data_valid_b, parity_err_a, parity_err_b;

  ram_dual_port_sync_be #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .MEMORY_DEPTH   (DEPTH),
    .READ_LATENCY   (LAT),
    .CLEAR_ON_RESET (1),
    .CLEAR_VALUE    (CV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ready        (ready),
    .enable_a     (enable_a),
    .enable_b     (enable_b),
    .rw_a         (rw_a),
    .rw_b         (rw_b),
    .byte_en_a    (byte_en_a),
    .byte_en_b    (byte_en_b),
    .address_a    (address_a),
    .address_b    (address_b),
    .data_in_a    (data_in_a),
    .data_in_b    (data_in_b),
    .data_out_a   (data_out_a),
    .data_out_b   (data_out_b),
    .data_valid_a (data_valid_a),
    .data_valid_b (data_valid_b),
    .parity_err_a (parity_err_a),
    .parity_err_b (parity_err_b)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  typedef struct {
    logic        en_a, rw_a;
    logic [1:0]  be_a;
    logic [15:0] addr_a, din_a, exp_a;
    logic        en_b, rw_b;
    logic [1:0]  be_b;
    logic [15:0] addr_b, din_b, exp_b;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Each read is due exactly LAT cycles after its accepting edge; anything else is a fault.
  always @(negedge clock) begin
    if (mon_on) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        ea = q_a.pop_front();
        chk("valid_a", 16'(data_valid_a), 16'd1);
        chk("data_a", data_out_a, ea.data);
        chk("perr_a", 16'(parity_err_a), 16'(ea.err));
      end else begin
        chk("idle_valid_a", 16'(data_valid_a), 16'd0);
      end
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        eb = q_b.pop_front();
        chk("valid_b", 16'(data_valid_b), 16'd1);
        chk("data_b", data_out_b, eb.data);
        chk("perr_b", 16'(parity_err_b), 16'(eb.err));
      end else begin
        chk("idle_valid_b", 16'(data_valid_b), 16'd0);
      end
    end
  end

  task automatic idle_inputs();
    enable_a = 1'b0; rw_a = 1'b0; byte_en_a = 2'b00; address_a = '0; data_in_a = '0;
    enable_b = 1'b0; rw_b = 1'b0; byte_en_b = 2'b00; address_b = '0; data_in_b = '0;
  endtask

  task automatic push_a(input logic [15:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.due = cyc + LAT;
    q_a.push_back(x);
  endtask

  task automatic push_b(input logic [15:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.due = cyc + LAT;
    q_b.push_back(x);
  endtask

  task automatic drive_vec(input vec_t v);
    enable_a = v.en_a; rw_a = v.rw_a; byte_en_a = v.be_a; address_a = v.addr_a; data_in_a = v.din_a;
    enable_b = v.en_b; rw_b = v.rw_b; byte_en_b = v.be_b; address_b = v.addr_b; data_in_b = v.din_b;
    if (v.en_a && !v.rw_a) push_a(v.exp_a, 1'b0);
    if (v.en_b && !v.rw_b) push_b(v.exp_b, 1'b0);
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 16'(ready), 16'd0);
    chk({tag, "_dout_a"}, data_out_a, 16'h0000);
    chk({tag, "_dout_b"}, data_out_b, 16'h0000);
  endtask

  // Counts edges from reset release until ready; optionally pokes requests mid-clear.
  task automatic wait_ready(input string name, input bit poke);
    int unsigned n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      if (poke && n == 10) begin
        enable_a = 1'b1; rw_a = 1'b1; byte_en_a = 2'b11; address_a = 16'd2; data_in_a = 16'h0000;
        enable_b = 1'b1; rw_b = 1'b0; address_b = 16'd2;
      end else if (n == 11) begin
        idle_inputs();
      end
      @(negedge clock);
      n++;
    end
    chk(name, n[15:0], 16'(DEPTH));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                 en rw be     addr    din      exp       en rw be     addr    din      exp
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 16'd2,   16'h0000, 16'hA5A5, 1'b1, 1'b0, 2'b00, 16'd63,  16'h0000, 16'hA5A5};
    vecs[1]  = '{1'b1, 1'b1, 2'b01, 16'd5,   16'h1234, 16'h0000, 1'b0, 1'b0, 2'b00, 16'd0,   16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 16'd5,   16'h0000, 16'hA534, 1'b0, 1'b0, 2'b00, 16'd0,   16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 2'b11, 16'd9,   16'hBEEF, 16'h0000, 1'b1, 1'b0, 2'b00, 16'd9,   16'h0000, 16'hA5A5};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 16'd0,   16'h0000, 16'h0000, 1'b1, 1'b0, 2'b00, 16'd9,   16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 16'd3,   16'h1111, 16'h0000, 1'b1, 1'b1, 2'b11, 16'd3,   16'h2222, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 16'd3,   16'h0000, 16'h2211, 1'b1, 1'b0, 2'b00, 16'd3,   16'h0000, 16'h2211};
    vecs[7]  = '{1'b1, 1'b1, 2'b11, 16'd64,  16'hFFFF, 16'h0000, 1'b1, 1'b0, 2'b00, 16'd64,  16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 16'd100, 16'h0000, 16'h0000, 1'b1, 1'b1, 2'b00, 16'd10,  16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 16'd10,  16'h0000, 16'hA5A5, 1'b1, 1'b0, 2'b00, 16'd0,   16'h0000, 16'hA5A5};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 16'd12,  16'h0000, 16'h0000, 1'b1, 1'b1, 2'b10, 16'd12,  16'h7700, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 16'd12,  16'h0000, 16'h77A5, 1'b1, 1'b0, 2'b00, 16'd5,   16'h0000, 16'hA534};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 16'd20,  16'h0000, 16'hA5A5, 1'b1, 1'b1, 2'b11, 16'd20,  16'hCAFE, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 16'd20,  16'h0000, 16'hCAFE, 1'b1, 1'b0, 2'b00, 16'd20,  16'h0000, 16'hCAFE};

    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    mon_on = 1'b1;
    check_reset_state("por");
    reset = 1'b0;
    wait_ready("clear_cycles", 1'b1);

    for (int unsigned i = 0; i < 14; i++) drive_vec(vecs[i]);
    idle_inputs();
    @(negedge clock);

    // Read accepted, then reset: with one-cycle latency it returns before the reset edge.
    enable_a = 1'b1; rw_a = 1'b0; address_a = 16'd5;
    if (LAT == 1) push_a(16'hA534, 1'b0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    enable_b = 1'b1; rw_b = 1'b0; address_b = 16'd9;
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    check_reset_state("rst_ready");

    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("rst_midclear");
    wait_ready("clear_after_midclear", 1'b0);

    enable_a = 1'b1; rw_a = 1'b0; address_a = 16'd5; push_a(16'hA5A5, 1'b0);
    enable_b = 1'b1; rw_b = 1'b0; address_b = 16'd9; push_b(16'hA5A5, 1'b0);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);

`ifdef RAM_PARITY_EN
    dut.mem[7] = dut.mem[7] ^ 16'h0001;
    enable_a = 1'b1; rw_a = 1'b0; address_a = 16'd7; push_a(16'hA5A4, 1'b1);
    @(negedge clock);
    idle_inputs();
`else
    enable_a = 1'b1; rw_a = 1'b0; address_a = 16'd7; push_a(16'hA5A5, 1'b0);
    @(negedge clock);
    idle_inputs();
`endif

    repeat (4) @(negedge clock);
    chk("pending_a", 16'(q_a.size()), 16'd0);
    chk("pending_b", 16'(q_b.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
